// File: rtl/audiodac_interp_pkg.sv
// Shared constants, encodings and helpers for the audio DAC interpolator.
// Build option AUDIODAC_INTERP_LINEAR_EN selects linear interpolation over zero-order hold.
package audiodac_pkg;

    localparam int DW        = 16;
    localparam int MAX_SHIFT = 8;
    localparam int ACC_W     = DW + 1 + MAX_SHIFT;
    localparam int SHIFT_W   = 4;
    localparam int PHASE_W   = MAX_SHIFT;

    localparam logic [SHIFT_W-1:0] SHIFT_RST = 4'd5;

    typedef enum logic [1:0] {
        OSR_32  = 2'd0,
        OSR_64  = 2'd1,
        OSR_128 = 2'd2,
        OSR_256 = 2'd3
    } osr_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic logic [SHIFT_W-1:0] osr_shift(input logic [1:0] sel);
        logic [SHIFT_W-1:0] s;
        case (osr_sel_e'(sel))
            OSR_32:  s = 4'd5;
            OSR_64:  s = 4'd6;
            OSR_128: s = 4'd7;
            OSR_256: s = 4'd8;
            default: s = 4'd5;
        endcase
        return s;
    endfunction

    // Last phase index of a period (OSR-1); OSR=256 wraps to 255 in 8 bits.
    function automatic logic [PHASE_W-1:0] osr_last(input logic [SHIFT_W-1:0] s);
        logic [PHASE_W:0] osr;
        osr = 9'd1 << s;
        return osr[PHASE_W-1:0] - 8'd1;
    endfunction

endpackage

// File: rtl/audiodac_interp_phase.sv
// Sequencer of the interpolator: IDLE/PRIME/RUN FSM, phase counter, OSR shift latch, read strobe.
// Build option AUDIODAC_INTERP_LINEAR_EN adds the latched shift output used by the linear datapath.
module audiodac_interp_phase
    import audiodac_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [1:0]         osr_sel_i,
    input  logic               mod_tick_i,
`ifdef AUDIODAC_INTERP_LINEAR_EN
    output logic [SHIFT_W-1:0] shift_o,
`endif
    output state_e             state_o,
    output logic               load_o
);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               period_end;

    assign period_end = (phase_q == osr_last(shift_q));

    // Strobe protocol: load_o is a one-cycle pull; upstream data is valid in the
    // same cycle and is consumed on the next clock edge. No backpressure exists.
    assign load_o = ~rst_i & en_i & mod_tick_i &
                    ((state_q == PRIME) | ((state_q == RUN) & period_end));

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            shift_q <= SHIFT_RST;
        end else begin
            case (state_q)
                IDLE: state_q <= PRIME;
                PRIME, RUN: begin
                    if (load_o) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        shift_q <= osr_shift(osr_sel_i);
                    end else if (mod_tick_i && state_q == RUN) begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;
`ifdef AUDIODAC_INTERP_LINEAR_EN
    assign shift_o = shift_q;
`endif

endmodule

// File: rtl/audiodac_interp.sv
// Upsampling interpolator feeding the delta-sigma modulator: one sample pulled per OSR ticks.
// AUDIODAC_INTERP_LINEAR_EN defined: linear ramp between samples; undefined: zero-order hold.
module audiodac_interp
    import audiodac_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [1:0]    osr_sel_i,
    input  logic          mod_tick_i,
    input  logic [DW-1:0] data_i,
    output logic          data_rd_o,
    output logic [DW-1:0] data_o
);

    state_e state;
    logic   load;
    logic   clear;
`ifdef AUDIODAC_INTERP_LINEAR_EN
    logic [SHIFT_W-1:0] shift;
`endif

    audiodac_interp_phase u_phase (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .osr_sel_i  (osr_sel_i),
        .mod_tick_i (mod_tick_i),
`ifdef AUDIODAC_INTERP_LINEAR_EN
        .shift_o    (shift),
`endif
        .state_o    (state),
        .load_o     (load)
    );

    assign data_rd_o = load;
    assign clear     = ~en_i | (state == IDLE);

`ifdef AUDIODAC_INTERP_LINEAR_EN
    // acc restarts at the previous sample scaled by OSR, so it also stands in for prev.
    logic [DW-1:0]           cur_q, cur_d;
    logic [DW:0]             delta_q, delta_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_shr;

    always_comb begin
        cur_d   = cur_q;
        delta_d = delta_q;
        acc_d   = acc_q;
        if (clear) begin
            cur_d   = '0;
            delta_d = '0;
            acc_d   = '0;
        end else if (load) begin
            cur_d   = data_i;
            delta_d = {data_i[DW-1], data_i} - {cur_q[DW-1], cur_q};
            acc_d   = {{(ACC_W-DW){cur_q[DW-1]}}, cur_q} << osr_shift(osr_sel_i);
        end else if (mod_tick_i && state == RUN) begin
            acc_d = acc_q + {{(ACC_W-DW-1){delta_q[DW]}}, delta_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q   <= '0;
            delta_q <= '0;
            acc_q   <= '0;
        end else begin
            cur_q   <= cur_d;
            delta_q <= delta_d;
            acc_q   <= acc_d;
        end
    end

    assign acc_shr = acc_q >>> shift;
    assign data_o  = acc_shr[DW-1:0];
`else
    logic [DW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (clear)     hold_d = '0;
        else if (load) hold_d = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) hold_q <= '0;
        else       hold_q <= hold_d;
    end

    assign data_o = hold_q;
`endif

endmodule

// File: tb/tb_audiodac_interp.sv
// Self-checking bench for audiodac_interp: vector table, directed corner sequences and random traffic.
// Expectations follow the AUDIODAC_INTERP_LINEAR_EN build setting of the design.
module tb_audiodac_interp;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  osr_sel_i = 2'd0;
    logic        mod_tick_i = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic        data_rd_o;
    logic [15:0] data_o;

    audiodac_interp dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .osr_sel_i  (osr_sel_i),
        .mod_tick_i (mod_tick_i),
        .data_i     (data_i),
        .data_rd_o  (data_rd_o),
        .data_o     (data_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        last_rd;
    logic [15:0] last_out;
    logic [15:0] exp_q[$];

    // Reference model: samples pulled so far, ticks since the last pull, OSR of the current period.
    bit m_active, m_primed;
    int m_ticks, m_osr, m_prev, m_cur, m_out;

    typedef struct {
        logic [15:0] data;
        logic        exp_rd;
        logic [15:0] exp_out;
    } vec_t;
    vec_t tbl[98];

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_primed = 0; m_ticks = 0; m_osr = 32;
        m_prev = 0; m_cur = 0; m_out = 0;
    endtask

    task automatic step(input logic rst, input logic en, input logic tick,
                        input logic [1:0] osr, input logic [15:0] data);
        logic exp_rd;
        @(negedge clk_i);
        rst_i = rst; en_i = en; mod_tick_i = tick; osr_sel_i = osr; data_i = data;
        #1;
        exp_rd = !rst && en && tick && m_active && (!m_primed || m_ticks == m_osr - 1);
        check("rd", 32'(data_rd_o), 32'(exp_rd));
        last_rd = data_rd_o;
        @(posedge clk_i);
        #1;
        if (rst || !en) begin
            model_clear();
        end else if (!m_active) begin
            m_active = 1;
        end else if (exp_rd) begin
            m_prev   = m_cur;
            m_cur    = $signed(data);
            m_osr    = 1 << (5 + osr);
            m_ticks  = 0;
            m_primed = 1;
`ifdef AUDIODAC_INTERP_LINEAR_EN
            m_out = m_prev;
`else
            m_out = m_cur;
`endif
        end else if (tick && m_primed) begin
            m_ticks++;
`ifdef AUDIODAC_INTERP_LINEAR_EN
            m_out = floor_div(m_prev * m_osr + m_ticks * (m_cur - m_prev), m_osr);
`endif
        end
        exp_q.push_back(m_out[15:0]);
        check("out", 32'(data_o), 32'(exp_q.pop_front()));
        last_out = data_o;
        cyc++;
    endtask

    task automatic wait_strobe(input int gap, input logic [1:0] osr, input logic [15:0] data,
                               input int max_cyc, output int nt);
        nt = 0;
        for (int c = 0; c < max_cyc; c++) begin
            logic tk;
            tk = ((c % gap) == gap - 1);
            step(1'b0, 1'b1, tk, osr, data);
            if (tk) nt++;
            if (last_rd) return;
        end
        checks++;
        failures++;
        $display("FAIL strobe_timeout: no strobe within %0d cycles", max_cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;
        model_clear();

        // Vector table: ramp from zero, flat period, then a large negative step.
        for (int i = 0; i < 98; i++) begin
            tbl[i].data   = (i < 65) ? 16'h1000 : 16'h8000;
            tbl[i].exp_rd = (i == 1 || i == 33 || i == 65 || i == 97);
`ifdef AUDIODAC_INTERP_LINEAR_EN
            if (i <= 1)       v = 0;
            else if (i <= 32) v = (i - 1) * 128;
            else if (i <= 65) v = 4096;
            else if (i <= 96) v = 4096 - 1152 * (i - 65);
            else              v = -32768;
`else
            if (i == 0)       v = 0;
            else if (i < 65)  v = 4096;
            else              v = -32768;
`endif
            tbl[i].exp_out = v[15:0];
        end

        // Reset held with enable and ticks active.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 2'd0, 16'($urandom));
            check("rst_rd", 32'(last_rd), 32'd0);
            check("rst_out", 32'(last_out), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 2'd0, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 2'd0, 16'h1234);

        for (int i = 0; i < 98; i++) begin
            step(1'b0, 1'b1, 1'b1, 2'd0, tbl[i].data);
            check($sformatf("tbl_rd[%0d]", i), 32'(last_rd), 32'(tbl[i].exp_rd));
            check($sformatf("tbl_out[%0d]", i), 32'(last_out), 32'(tbl[i].exp_out));
        end

        // OSR switched to 256 mid-period: current period still 32 ticks, next one 256.
        for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 1'b1, 2'd0, 16'($urandom));
        wait_strobe(1, 2'd3, 16'h3A5C, 400, n);
        check("osr_gap_old", 32'(n), 32'd23);
        wait_strobe(1, 2'd3, 16'hD001, 400, n);
        check("osr_gap_new", 32'(n), 32'd256);

        // Gapped ticks, then enable dropped at phase 7 and restored.
        wait_strobe(4, 2'd0, 16'h7FFF, 1200, n);
        check("gap_period", 32'(n), 32'd256);
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0, 2'd0, 16'($urandom));
            step(1'b0, 1'b1, 1'b1, 2'd0, 16'($urandom));
        end
        step(1'b0, 1'b0, 1'b1, 2'd0, 16'h5555);
        check("drop_rd", 32'(last_rd), 32'd0);
        check("drop_out", 32'(last_out), 32'd0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 16'h5555);
        step(1'b0, 1'b1, 1'b1, 2'd0, 16'h2222);
        check("reen_idle_rd", 32'(last_rd), 32'd0);
        step(1'b0, 1'b1, 1'b1, 2'd0, 16'h2222);
        check("reen_first_rd", 32'(last_rd), 32'd1);

        // Alternating full-scale samples, OSR toggling between 32 and 64.
        for (int s = 0; s < 6; s++) begin
            wait_strobe(1, 2'(s % 2), (s % 2 == 1) ? 16'hC000 : 16'h4000, 600, n);
            check($sformatf("alt_gap[%0d]", s), 32'(n),
                  32'((s == 0) ? 32 : (32 << ((s - 1) % 2))));
        end

        // Random traffic against the model.
        begin
            logic [1:0] osr;
            osr = 2'd0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 49) == 0) osr = 2'($urandom_range(0, 3));
                step(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) > 1),
                     ($urandom_range(0, 2) != 0), osr, 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audiodac_interp.md
Name: audiodac_interp

Overview:
- Upsampling interpolator between the test sine generator (or any 16b sample source with a read strobe) and the delta-sigma modulator.
- Pulls one signed 16b sample per OSR modulator ticks through a single-cycle read strobe.
- Emits one linearly interpolated signed 16b sample per modulator tick, so the modulator sees a smooth ramp instead of a staircase.

Parameters:
- DW, 16, sample width in and out (two's complement).
- MAX_SHIFT, 8, log2 of the largest OSR; sets accumulator width ACC_W = DW+1+MAX_SHIFT = 25.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  block enable; low forces IDLE.
- osr_sel_i  in  2  OSR select: 0→32, 1→64, 2→128, 3→256 (shift S = 5..8).
- mod_tick_i  in  1  modulator sample strobe; one interpolated output per high cycle.
- data_i  in  DW  upstream sample; valid whenever data_rd_o is high.
- data_rd_o  out  1  single-cycle read strobe to upstream (drives sinegen data_rd_i).
- data_o  out  DW  interpolated sample to the modulator, signed.

Behaviour:
- Reset, sampled on the clk_i edge with rst_i=1:
  - state=IDLE; phase, prev, cur, delta and acc cleared; S latched to 5.
  - data_o=0, data_rd_o=0.
- States:
  - IDLE: en_i=0. Registers held at 0; data_o=0.
  - PRIME: first tick after enable. Leaves IDLE for PRIME on the cycle after en_i=1 is seen.
  - RUN: normal interpolation.
- data_rd_o is combinational: en_i & mod_tick_i & (state==PRIME | (state==RUN & phase==OSR-1)).
  - Pulse width is always exactly one cycle.
  - Never asserted without mod_tick_i.
  - data_i is captured on the same edge.
- Load edge (data_rd_o=1):
  - prev<=cur; cur<=data_i; delta<=data_i-cur (DW+1 bits, sign-extended).
  - acc<=cur<<<S_new; phase<=0; S latched from osr_sel_i.
  - PRIME→RUN.
- Non-load tick in RUN: acc<=acc+delta; phase<=phase+1.
- data_o = acc>>>S, arithmetic shift with floor truncation, sliced from the acc register. Outputs are registered with a 1-cycle latency from the tick edge.
- After tick k (0..OSR-1) of a period: data_o = floor(prev + k·delta/OSR).
  - acc stays between prev and cur, so it never overflows.
  - No saturation logic is required.
- Cycles without mod_tick_i hold all state.
- osr_sel_i changes mid-period are ignored until the next load edge.
- en_i falling mid-period: next edge → IDLE, all cleared, data_o=0, no strobe. The in-flight sample is discarded.
- rst_i has priority over en_i and mod_tick_i.
- Inherent group delay: one input sample period.

Optional Feature:
- Macro: AUDIODAC_INTERP_LINEAR_EN.
- Defined: linear interpolation as described above.
- Undefined: zero-order hold.
  - delta and acc are removed.
  - data_o<=data_i on each load edge and is held between loads.
  - No one-sample delay.
  - Strobe timing, phase counter and FSM are identical in both builds.

Decomposition:
- Package audiodac_pkg holds:
  - DW, MAX_SHIFT, ACC_W.
  - osr_sel encodings and the OSR_SEL→shift mapping function.
  - State enum {IDLE, PRIME, RUN}.
- Sub-module audiodac_interp_phase holds the FSM, the 8b phase counter, the S latch and data_rd_o generation.
- The datapath (prev/cur/delta/acc) stays in the top module.

Test Plan:
1. Reset: rst_i=1 for 3 cycles with en_i=1 and mod_tick_i=1 → data_o=0, data_rd_o=0 throughout. State is IDLE after release until en_i is seen.
2. Ramp: osr_sel=0, mod_tick_i every cycle, data_i=0x1000 constant.
   - First strobe on the first tick.
   - Second period: data_o=k·0x0080 for k=0..31.
   - Third period: constant 0x1000.
   - data_rd_o exactly every 32 ticks.
3. Negative step: cur=0x1000, next data_i=0x8000.
   - delta=-36864; data_o steps -1152 per tick: 0x1000, 0x0B80, …, ending at 0x8480.
   - No wrap.
4. OSR change: switch osr_sel 0→3 at tick 10 of a period → that period still ends after 32 ticks; the next period spans 256 ticks with steps of delta/256.
5. Gapped ticks and enable drop:
   - mod_tick_i every 4th cycle → data_o changes only one cycle after ticks, and data_rd_o is coincident with a tick.
   - Drop en_i at phase 7 → data_o=0 next cycle and no strobe.
   - Re-enable → strobe on the first tick.
6. Build without AUDIODAC_INTERP_LINEAR_EN, data_i alternating 0x4000/0xC000 per strobe → data_o holds each value for exactly OSR ticks, updated one cycle after the strobe edge.
